alu_exec_ctrl: RTL

Execute-stage sequencer wrapped around the team's ALU opcode set (NOP, LV, mlt, div, rest, sum, CP, B, BEG, slr, GP).
- Accepts one decoded instruction at a time over a valid/ready handshake.
- Runs single-cycle ops in one cycle and div as a multi-cycle restoring divider.
- Presents a registered writeback result with backpressure.
- Raises a one-cycle branch/flush pulse toward fetch.
- Sits between decode/register-read and the writeback stage.

---
 rtl/alu_exec_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts decoded ALU ops over valid/ready, runs single-cycle ops
// directly, runs unsigned div as a restoring divider, and emits registered writeback plus
// one-cycle branch/flush and illegal-opcode pulses.
module alu_exec_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RD_W  = 7,
  parameter int unsigned OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_opcode,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [WIDTH-1:0] in_rs,
  input  logic [WIDTH-1:0] in_rsi,
  input  logic [WIDTH-1:0] in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_opcode,
  output logic [RD_W-1:0]  out_rd,
  output logic [WIDTH-1:0] out_result,
  output logic             branch_taken,
  output logic [RD_W-1:0]  branch_target,
  output logic             flush,
  output logic             busy,
  output logic             err_illegal
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [OP_W-1:0] OpNop  = OP_W'(0);
  localparam logic [OP_W-1:0] OpLv   = OP_W'(1);
  localparam logic [OP_W-1:0] OpMlt  = OP_W'(2);
  localparam logic [OP_W-1:0] OpDiv  = OP_W'(3);
  localparam logic [OP_W-1:0] OpRest = OP_W'(4);
  localparam logic [OP_W-1:0] OpSum  = OP_W'(5);
  localparam logic [OP_W-1:0] OpCp   = OP_W'(6);
  localparam logic [OP_W-1:0] OpB    = OP_W'(7);
  localparam logic [OP_W-1:0] OpBeg  = OP_W'(8);
  localparam logic [OP_W-1:0] OpSlr  = OP_W'(9);
  localparam logic [OP_W-1:0] OpGp   = OP_W'(10);

  typedef enum logic [1:0] {StIdle, StDiv, StWaitOut} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] dvd_q;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CntW-1:0]  cnt_q;
  logic [RD_W-1:0]  div_rd_q;

  logic             out_free;
  logic             accept;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] wb_result;
  logic             beg_taken;

  // Handshake, one restoring-divide step and single-cycle result decode
  always_comb begin
    out_free  = !out_valid || out_ready;
    in_ready  = (state_q == StIdle) && out_free;
    accept    = in_valid && in_ready;
    busy      = (state_q != StIdle);

    div_sh    = {rem_q, dvd_q[WIDTH-1]};
    div_diff  = div_sh - {1'b0, dvs_q};
    q_bit     = !div_diff[WIDTH];
    rem_next  = q_bit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    quo_next  = {dvd_q[WIDTH-2:0], q_bit};

    beg_taken = {{(WIDTH-RD_W){1'b0}}, in_rd} > in_rs;

    wb_result = '0;
    case (in_opcode)
      OpLv, OpCp: wb_result = in_rsi;
      OpMlt:      wb_result = in_rs * in_rt;
      OpRest:     wb_result = in_rs - in_rt;
      OpSum:      wb_result = in_rs + in_rt;
      OpSlr:      wb_result = (in_rt >= WIDTH'(WIDTH)) ? '0 : (in_rs << in_rt[CntW-1:0]);
      OpGp:       wb_result = in_rs;
      default:    wb_result = '0;
    endcase
  end

  // Sequencer state, divider datapath and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      div_rd_q      <= '0;
      out_valid     <= 1'b0;
      out_opcode    <= '0;
      out_rd        <= '0;
      out_result    <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      flush         <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      branch_taken <= 1'b0;
      flush        <= 1'b0;
      err_illegal  <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state_q)
        StIdle: begin
          if (accept) begin
            case (in_opcode)
              OpNop: ;
              OpLv, OpMlt, OpRest, OpSum, OpCp, OpSlr, OpGp: begin
                out_valid  <= 1'b1;
                out_opcode <= in_opcode;
                out_rd     <= in_rd;
                out_result <= wb_result;
              end
              OpDiv: begin
                if (in_rt == '0) begin
                  out_valid  <= 1'b1;
                  out_opcode <= in_opcode;
                  out_rd     <= in_rd;
                  out_result <= '1;
                end else begin
                  dvd_q    <= in_rs;
                  dvs_q    <= in_rt;
                  rem_q    <= '0;
                  cnt_q    <= '0;
                  div_rd_q <= in_rd;
                  state_q  <= StDiv;
                end
              end
              OpB: begin
                branch_taken  <= 1'b1;
                flush         <= 1'b1;
                branch_target <= in_rd;
              end
              OpBeg: begin
                if (beg_taken) begin
                  branch_taken  <= 1'b1;
                  flush         <= 1'b1;
                  branch_target <= in_rt[RD_W-1:0];
                end
              end
              default: err_illegal <= 1'b1;
            endcase
          end
        end
        StDiv: begin
          rem_q <= rem_next;
          dvd_q <= quo_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            if (out_free) begin
              out_valid  <= 1'b1;
              out_opcode <= OpDiv;
              out_rd     <= div_rd_q;
              out_result <= quo_next;
              state_q    <= StIdle;
            end else begin
              state_q <= StWaitOut;
            end
          end
        end
        StWaitOut: begin
          // Quotient parked in dvd_q until the writeback register frees up
          if (out_free) begin
            out_valid  <= 1'b1;
            out_opcode <= OpDiv;
            out_rd     <= div_rd_q;
            out_result <= dvd_q;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
